// File: rtl/lsu_if.sv
// lsu_if: word-addressed request/acknowledge data-memory port with byte enables
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu.sv
// lsu: RV32I memory stage with lane steering, load extension, ack timeout and registered writeback
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ex_valid,
    input  logic        i_ex_memRead,
    input  logic        i_ex_memWrite,
    input  logic        i_ex_regWrite,
    input  logic [2:0]  i_ex_funct3,
    input  logic [4:0]  i_ex_rd,
    input  logic [31:0] i_ex_addr,
    input  logic [31:0] i_ex_result,
    input  logic [31:0] i_ex_storeData,
    output logic        o_stall,
    lsu_if.master       mem,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_wb_regWrite,
    output logic        o_wb_fault,
    output logic [1:0]  o_wb_faultCause
);
    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_regWrite;
    logic        r_wb_fault;
    logic [1:0]  r_wb_cause;
    logic        w_mem;
    logic        w_ill;
    logic        w_mis;
    logic        w_bad;
    logic        w_go;
    logic        w_done;
    logic        w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    always_comb begin
        w_mem   = i_ex_memRead | i_ex_memWrite;
        w_ill   = (i_ex_memRead & i_ex_memWrite)
                | (i_ex_memRead & (i_ex_funct3 == 3'b011 || i_ex_funct3[2:1] == 2'b11))
                | (i_ex_memWrite & (i_ex_funct3 > 3'b010));
        w_mis   = (i_ex_funct3[1:0] == 2'b01 && i_ex_addr[0])
                | (i_ex_funct3[1:0] == 2'b10 && i_ex_addr[1:0] != 2'b00);
        w_bad   = i_ex_valid & w_mem & (w_ill | w_mis);
        w_go    = (r_state == S_IDLE) & i_ex_valid & w_mem & ~w_ill & ~w_mis;
        w_done  = (r_state == S_REQ) & mem.ack;
        w_tmo   = (r_state == S_REQ) & ~mem.ack & (r_cnt == 8'(TIMEOUT - 1));
        o_stall = w_go | ((r_state == S_REQ) & ~mem.ack & ~w_tmo);
        w_be    = i_ex_funct3[1:0] == 2'b00 ? 4'b0001 << i_ex_addr[1:0] :
                  i_ex_funct3[1:0] == 2'b01 ? (i_ex_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata = i_ex_funct3[1:0] == 2'b00 ? {4{i_ex_storeData[7:0]}} :
                  i_ex_funct3[1:0] == 2'b01 ? {2{i_ex_storeData[15:0]}} : i_ex_storeData;
        w_shift = mem.rdata >> {r_off, 3'b000};
        w_load  = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_shift[7]}}, w_shift[7:0]} :
                  r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]} : w_shift;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_off         <= '0;
            r_f3          <= '0;
            r_rd          <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_wb_regWrite <= 1'b0;
            r_wb_fault    <= 1'b0;
            r_wb_cause    <= '0;
        end else if (r_state == S_IDLE) begin
            r_wb_valid    <= i_ex_valid & ~w_go;
            r_wb_rd       <= i_ex_rd;
            r_wb_data     <= w_mem ? '0 : i_ex_result;
            r_wb_regWrite <= i_ex_valid & ~w_mem & i_ex_regWrite;
            r_wb_fault    <= w_bad;
            r_wb_cause    <= ~w_bad ? 2'b00 : w_ill ? 2'b11 : 2'b01;
            if (w_go) begin
                r_state <= S_REQ;
                r_cnt   <= '0;
                r_off   <= i_ex_addr[1:0];
                r_f3    <= i_ex_funct3;
                r_rd    <= i_ex_rd;
                r_we    <= i_ex_memWrite;
                r_addr  <= {i_ex_addr[31:2], 2'b00};
                r_wdata <= i_ex_memWrite ? w_wdata : '0;
                r_be    <= w_be;
            end
        end else begin
            r_wb_valid    <= w_done | w_tmo;
            r_wb_rd       <= r_rd;
            r_wb_data     <= (w_done & ~r_we) ? w_load : '0;
            r_wb_regWrite <= w_done & ~r_we;
            r_wb_fault    <= w_tmo;
            r_wb_cause    <= w_tmo ? 2'b10 : 2'b00;
            r_cnt         <= r_cnt + 8'd1;
            if (w_done | w_tmo) r_state <= S_IDLE;
        end
    end
    assign mem.req         = r_state == S_REQ;
    assign mem.we          = r_we;
    assign mem.addr        = r_addr;
    assign mem.wdata       = r_wdata;
    assign mem.be          = r_be;
    assign o_wb_valid      = r_wb_valid;
    assign o_wb_rd         = r_wb_rd;
    assign o_wb_data       = r_wb_data;
    assign o_wb_regWrite   = r_wb_regWrite;
    assign o_wb_fault      = r_wb_fault;
    assign o_wb_faultCause = r_wb_cause;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit forming the memory stage of the pipelined RV32I core, directly downstream of the ALU. It takes the ALU output as the effective address, the forwarded rs2 as store data, and the ALU result for non-memory instructions. It drives a word-addressed request/acknowledge data-memory port with byte enables, aligns and extends load data, and registers everything into the writeback stage. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
- TIMEOUT, 255: maximum cycles to wait for mem_ack before aborting with a fault (1..255; counter is 8 bits).

- clk  in  1  core clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  instruction present from the ALU stage.
- ex_memRead  in  1  instruction is a load.
- ex_memWrite  in  1  instruction is a store.
- ex_regWrite  in  1  non-memory instruction writes rd.
- ex_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_rd  in  5  destination register.
- ex_addr  in  32  effective address (ALU aluOut).
- ex_result  in  32  ALU result for non-memory instructions.
- ex_storeData  in  32  forwarded rs2.
- stall  out  1  hold upstream stages this cycle (combinational).
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  request completed this cycle; mem_rdata valid when a read.
- mem_rdata  in  32  read word.
- wb_valid  out  1  writeback slot valid.
- wb_rd  out  5  destination register.
- wb_data  out  32  load result or passed ALU result.
- wb_regWrite  out  1  register file write enable.
- wb_fault  out  1  instruction faulted.
- wb_faultCause  out  2  01 misaligned, 10 timeout, 11 illegal funct3 or memRead&memWrite; 00 when no fault.

## Operation
- States: IDLE, REQ.
- IDLE, ex_valid=0: next cycle wb_valid=0.
- IDLE, ex_valid, no mem op: next cycle wb_valid=1, wb_data=ex_result, wb_regWrite=ex_regWrite, wb_rd=ex_rd.
- IDLE, mem op, fault detected (misaligned: H with addr[0]=1, W with addr[1:0]!=0; illegal: load funct3 011/110/111, store funct3 >010, both read and write): no request; next cycle wb_valid=1, wb_fault=1, wb_regWrite=0, cause set.
- IDLE, legal mem op: latch address, size, sign, rd, store lanes; go to REQ; stall=1 this cycle.
- REQ: mem_req=1 with mem_addr/mem_we/mem_wdata/mem_be held stable until ack. Store lanes: SB wdata={4{d[7:0]}}, be=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, be=addr[1]?1100:0011; SW wdata=d, be=1111. Loads: be per same rule, mem_we=0, mem_wdata=0.
- REQ with mem_ack: go IDLE; next cycle wb_valid=1. Loads: wb_data = (mem_rdata >> 8*addr[1:0]) truncated to size, sign-extended for B/H, zero-extended for BU/HU; wb_regWrite=1. Stores: wb_regWrite=0, wb_data=0.
- Timeout counter clears on REQ entry and increments each REQ cycle without ack. A REQ cycle with counter == TIMEOUT-1 and no ack aborts: go IDLE, mem_req low next cycle; next cycle wb_valid=1, wb_fault=1, cause 10, wb_regWrite=0. Ack on that same cycle wins over timeout.
- mem_ack in IDLE is ignored, including a late ack after timeout.
- stall = (IDLE & ex_valid & legal mem op) | (REQ & !mem_ack & !timeout_hit).
- ex_* inputs are sampled only in IDLE. The held copy presented during REQ is ignored.

## Timing
- Reset: state IDLE, counter 0. All outputs 0 (stall follows its equation with state IDLE). Asserting reset mid-REQ drops mem_req immediately with no writeback.
- Non-memory or faulting instruction: 1-cycle latency, no stall.
- Memory op accepted at cycle 0. mem_req is high from cycle 1. Ack at cycle k≥1 gives wb_valid at k+1. stall is high for cycles 0..k-1. The next instruction is presented at cycle k+1 and may be accepted then (back-to-back requests, with mem_req low at k+1).
- All wb_* outputs are registered.

## Test plan
- ALU passthrough: ex_result=0x1234, rd=5, regWrite=1, no mem op -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall=0.
- SB addr=0x1003, data=0xAB, ack after 3 cycles -> mem_addr=0x1000, be=1000, wdata=0xABABABAB held 3 cycles, stall high 3 cycles, wb_regWrite=0.
- LB addr=0x2002, rdata=0x0080FF00, ack on first REQ cycle -> wb_data=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr=0x2002 -> 0x00000080.
- LW addr=0x3001 -> no mem_req; next cycle wb_fault=1, cause 01, wb_regWrite=0. funct3=011 load -> cause 11.
- TIMEOUT=4, no ack -> mem_req high 4 cycles then low; wb_fault cause 10; later ack ignored.
- Reset asserted mid-REQ -> mem_req and all wb_* are 0 immediately; the next legal load proceeds normally.
